// File: rtl/board_move_collector.sv
// Board move collector: drains the column move FIFOs round-robin
// and streams the valid move slots out one per cycle.
module board_move_collector #(
  parameter int NCOL   = 8,
  parameter int MOVE_W = 19,
  parameter int SLOTS  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NCOL-1:0]               col_done,
  input  logic [NCOL-1:0]               col_empty,
  input  logic [NCOL*SLOTS*MOVE_W-1:0]  col_data,
  output logic [NCOL-1:0]               col_rden,
  output logic [MOVE_W-1:0]             move_out,
  output logic                          move_valid,
  input  logic                          move_ready,
  output logic [CNT_W-1:0]              move_count,
  output logic                          busy,
  output logic                          done
);

  localparam int WORD_W = SLOTS * MOVE_W;

  typedef enum logic [2:0] {
    IDLE, SCAN, READ, LOAD, UNPACK, DONE
  } state_t;

  state_t              state;
  logic [2:0]          rr_ptr;
  logic [2:0]          sel;
  logic [WORD_W-1:0]   word;
  logic [SLOTS-1:0]    mask;

  logic                scan_hit;
  logic [2:0]          scan_sel;
  logic [2:0]          scan_idx;
  logic [WORD_W-1:0]   ld_word;
  logic [SLOTS-1:0]    ld_mask;
  logic [SLOTS-1:0]    nxt_mask;

  function automatic logic [2:0] lowest(input logic [SLOTS-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = SLOTS - 1; k >= 0; k--)
      if (m[k]) r = 3'(k);
    return r;
  endfunction

  function automatic logic [MOVE_W-1:0] slot_of(
    input logic [WORD_W-1:0] w,
    input logic [2:0]        k
  );
    return w[32'(k)*MOVE_W +: MOVE_W];
  endfunction

  // First non-empty column at or after the round-robin pointer.
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = rr_ptr;
    scan_idx = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      scan_idx = rr_ptr + 3'(i);
      if (!col_empty[scan_idx]) begin
        scan_hit = 1'b1;
        scan_sel = scan_idx;
      end
    end
  end

  // Selected column's word and its valid-slot mask (bit 18 = invalid).
  always_comb begin
    ld_word = col_data[32'(sel)*WORD_W +: WORD_W];
    ld_mask = '0;
    for (int k = 0; k < SLOTS; k++)
      ld_mask[k] = ~ld_word[k*MOVE_W + MOVE_W - 1];
  end

  // Remaining slots once the presented move is accepted.
  always_comb begin
    nxt_mask = mask & ~(SLOTS'(1) << lowest(mask));
  end

  // Read strobe is gated by the live empty flag so a column that
  // went empty after SCAN is never read.
  assign col_rden = (state == READ && !col_empty[sel])
                    ? (NCOL'(1) << sel) : '0;

  assign busy = (state == SCAN) || (state == READ) ||
                (state == LOAD) || (state == UNPACK);
  assign done = (state == DONE);

  // Collection FSM with registered move stream and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      sel        <= '0;
      word       <= '0;
      mask       <= '0;
      move_out   <= '0;
      move_valid <= 1'b0;
      move_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SCAN;
            move_count <= '0;
            rr_ptr     <= '0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            sel   <= scan_sel;
            state <= READ;
          end else if (&col_done && &col_empty) begin
            state <= DONE;
          end
        end
        READ: begin
          if (col_empty[sel]) begin
            state <= SCAN;
          end else begin
            rr_ptr <= sel + 3'd1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          word <= ld_word;
          mask <= ld_mask;
          if (ld_mask == '0) begin
            state <= SCAN;
          end else begin
            move_out   <= slot_of(ld_word, lowest(ld_mask));
            move_valid <= 1'b1;
            state      <= UNPACK;
          end
        end
        UNPACK: begin
          if (move_ready) begin
            if (move_count != '1)
              move_count <= move_count + 1'b1;
            mask <= nxt_mask;
            if (nxt_mask == '0) begin
              move_valid <= 1'b0;
              state      <= SCAN;
            end else begin
              move_out <= slot_of(word, lowest(nxt_mask));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
